decoder_2to4: RTL and testbench
===============================

# decoder_2to4

Registered binary-to-one-hot decoder: a W-bit select code is decoded into a 2^W-bit one-hot output word, sampled on the rising clock edge. It sits in control paths that fan a small encoded select (mux/bank/chip select) out to individual enable lines. The default configuration, W=2, is the classic 2-to-4 decoder.

## Interface
- `W`, default 2: select width; legal range 1..6; output width is 2^W.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: decode enable; when low, no output line is asserted.
- `S` input W: binary select code.
- `Y` output 2^W: registered one-hot decode result.
- `valid` output 1: registered flag; high when `Y` holds a decode of an enabled `S`.

## Operation
- Each rising edge of `clk` with `rst`=0 and `en`=1:
  - `Y` bit `S` becomes active.
  - All other `Y` bits become inactive.
  - `valid` becomes 1.
- Each rising edge with `rst`=0 and `en`=0:
  - All `Y` bits become inactive.
  - `valid` becomes 0.
- Each rising edge with `rst`=1:
  - All `Y` bits become inactive.
  - `valid` becomes 0.
  - `rst` has priority over `en` and `S`.
- `Y` bit ordering: Y[0] corresponds to S=0 and Y[2^W-1] to S=all-ones.
  - For W=2: S=00 gives Y=0001, S=01 gives Y=0010, S=10 gives Y=0100, S=11 gives Y=1000.
- Every value of `S` is legal. There is no out-of-range case.
- Output invariant: when `valid`=1, exactly one bit of `Y` is active. When `valid`=0, zero bits are active.
- X/Z on `S` while `en`=1 is a usage error. The output is then undefined until the next clean decode or reset.
- There is no internal state beyond the `Y` and `valid` registers.

## Timing
- Latency: 1 cycle. `Y` and `valid` reflect the `S`/`en` sampled at the previous rising edge.
- Throughput: a new code every cycle. Back-to-back changes of `S` produce back-to-back one-hot words with no bubble.
- Reset value: `valid`=0 and `Y`=all-inactive. This equals 0 in normal polarity and all-ones in active-low mode.
  - Reset applies at the first edge where `rst`=1.
  - Reset mid-stream discards the in-flight code.
  - The first decode after reset deasserts appears one cycle after the first edge with `rst`=0 and `en`=1.
- `en` and `S` changing in the same cycle: both are sampled together. There is no ordering dependency.
- Outputs are glitch-free (direct flop outputs). There is no combinational path from any input to any output.

## Configuration
- Macro `DECODER_ACTIVE_LOW_EN`:
  - Undefined (default): active level is 1.
    - Inactive `Y` bits are 0.
    - Reset/disabled `Y` = all zeros.
  - Defined: active level is 0.
    - The selected bit is 0 and all others are 1.
    - Reset/disabled `Y` = all ones (W=2: 1111; S=10 gives Y=1011).
  - `valid` polarity is active-high in both builds.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `en`=1 and S=11 -> `Y`=0000 and `valid`=0 throughout; after release, the first enabled edge yields `Y`=1000 and `valid`=1 one cycle later.
- Sweep: with `en`=1, drive S=00, 01, 10, 11, each for 10 cycles -> `Y`=0001, 0010, 0100, 1000, each lagging S by one cycle; `valid`=1; the one-hot invariant is checked every cycle.
- Enable gating: S=10 with `en` toggled 1,0,1 -> `Y`=0100/`valid`=1, then `Y`=0000/`valid`=0, then `Y`=0100/`valid`=1, each one cycle after the `en` change.
- Back-to-back: change S every cycle in the order 00,11,01,10 -> `Y`=0001,1000,0010,0100 on consecutive cycles with no bubble.
- Mid-stream reset: assert `rst` for one cycle while S=01 and `en`=1 -> `Y`=0000/`valid`=0 for exactly that cycle's result, then `Y`=0010 resumes.
- Active-low build (`DECODER_ACTIVE_LOW_EN` defined): reset -> `Y`=1111; S=01 with `en`=1 -> `Y`=1101 and `valid`=1.

Source files
------------

// File: rtl/decoder_2to4_if.sv
// decoder_2to4_if: bundles the decoder's select/enable request and its
// registered one-hot response.
//   W      : select width (1..6); Y is 2**W bits wide
//   en     : decode enable (driven by master)
//   S      : binary select code (driven by master)
//   Y      : registered one-hot decode word (driven by slave)
//   valid  : registered flag, high when Y holds an enabled decode (slave)
interface decoder_2to4_if #(
  parameter int unsigned W = 2
);
  logic                en;
  logic [W-1:0]        S;
  logic [(1<<W)-1:0]   Y;
  logic                valid;

  modport master (output en, output S, input Y, input valid);
  modport slave  (input en, input S, output Y, output valid);
endinterface

// File: rtl/decoder_2to4.sv
// decoder_2to4: registered binary-to-one-hot decoder.
// A W-bit select S is decoded into a 2**W-bit word Y on each rising clk
// edge; Y[0] corresponds to S=0. Both outputs come straight from flops.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (priority over en and S)
//   bus : decoder_2to4_if.slave (en, S in; Y, valid out)
// Build option:
//   DECODER_ACTIVE_LOW_EN defined   -> Y is active-low (selected bit 0,
//                                      idle/reset word all ones)
//   DECODER_ACTIVE_LOW_EN undefined -> Y is active-high (idle word zero)
// valid is active-high in both builds.
module decoder_2to4 #(
  parameter int unsigned W = 2
) (
  input  logic           clk,
  input  logic           rst,
  decoder_2to4_if.slave  bus
);
  localparam int unsigned N = 1 << W;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic         ACTIVE_BIT = 1'b0;
  localparam logic [N-1:0] IDLE_WORD  = '1;
`else
  localparam logic         ACTIVE_BIT = 1'b1;
  localparam logic [N-1:0] IDLE_WORD  = '0;
`endif

  logic [N-1:0] y_d, y_q;
  logic         valid_d, valid_q;

  always_comb begin
    y_d     = IDLE_WORD;
    valid_d = 1'b0;
    if (bus.en) begin
      y_d[bus.S] = ACTIVE_BIT;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= IDLE_WORD;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Y     = y_q;
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_decoder_2to4.sv
// tb_decoder_2to4: randomized + directed bench for decoder_2to4 with a
// queue-based scoreboard. Each rising edge pushes the response predicted
// from the sampled rst/en/S; a monitor pops and compares on the falling edge.
module tb_decoder_2to4;
  localparam int unsigned W = 2;
  localparam int unsigned N = 1 << W;
`ifdef DECODER_ACTIVE_LOW_EN
  localparam bit ACT_LOW = 1'b1;
`else
  localparam bit ACT_LOW = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] y;
    logic         v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic stop_push = 1'b0;
  int   errors = 0;
  int   checks = 0;
  string phase = "reset";
  exp_t  q[$];
  exp_t  cur;
  int    hot_count;

  decoder_2to4_if #(.W(W)) bus();

  decoder_2to4 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: decode is a single set bit at position S, inverted in the
  // active-low build; reset or disable yields the idle word.
  function automatic exp_t model(logic r, logic e, logic [W-1:0] s);
    exp_t x;
    int unsigned idx;
    logic [N-1:0] hot;
    hot = '0;
    if (!r && e) begin
      idx = int'(s);
      hot = N'(2 ** idx);
    end
    x.y = ACT_LOW ? ~hot : hot;
    x.v = !r && e;
    return x;
  endfunction

  always @(posedge clk) begin
    if (!stop_push) q.push_back(model(rst, bus.en, bus.S));
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      checks++;
      if (bus.Y !== cur.y || bus.valid !== cur.v) begin
        errors++;
        $display("FAIL %s: got Y=%b valid=%b, expected Y=%b valid=%b",
                 phase, bus.Y, bus.valid, cur.y, cur.v);
      end
      hot_count = $countones(ACT_LOW ? ~bus.Y : bus.Y);
      checks++;
      if (hot_count != (bus.valid === 1'b1 ? 1 : 0)) begin
        errors++;
        $display("FAIL %s onehot: got %0d active bits with valid=%b, expected %0d",
                 phase, hot_count, bus.valid, (bus.valid === 1'b1 ? 1 : 0));
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [W-1:0] s);
    rst    = r;
    bus.en = e;
    bus.S  = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    bus.en = 1'b1;
    bus.S  = 2'b11;

    phase = "reset";
    step(1'b1, 1'b1, 2'b11);
    step(1'b1, 1'b1, 2'b11);
    phase = "release";
    step(1'b0, 1'b1, 2'b11);

    phase = "sweep";
    for (int unsigned s = 0; s < N; s++)
      for (int unsigned c = 0; c < 10; c++)
        step(1'b0, 1'b1, W'(s));

    phase = "enable_gate";
    step(1'b0, 1'b1, 2'b10);
    step(1'b0, 1'b0, 2'b10);
    step(1'b0, 1'b1, 2'b10);

    phase = "back_to_back";
    step(1'b0, 1'b1, 2'b00);
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b10);

    phase = "midstream_reset";
    step(1'b0, 1'b1, 2'b01);
    step(1'b1, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b01);

    phase = "random";
    for (int unsigned i = 0; i < 300; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), W'($urandom));

    stop_push = 1'b1;
    for (int unsigned i = 0; i < 3 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
